// File: rtl/if_fetch_if.sv
// Byte-wide memory read port between the fetch unit (master) and memory (slave).
//   mem_req   : fetch -> mem, byte-read request
//   mem_addr  : fetch -> mem, byte address of the current request
//   mem_ready : mem -> fetch, one byte returned this cycle
//   mem_rdata : mem -> fetch, returned byte, valid with mem_ready
interface if_fetch_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BYTE_W = 8;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [BYTE_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit little-endian word from four byte
// reads, presents it in HOLD until the pipeline accepts it, and redirects on
// branch_flag.
//   clk_in, rst_in : clock, synchronous active-high reset
//   stall          : stall vector, only bit 0 (fetch hold) is used
//   branch_flag    : redirect pulse, branch_target is the new byte address
//   mem            : byte-read memory port (master side)
//   if_pc, if_inst : fetched instruction address and word, valid with if_valid
//   stall_if       : combinational, high while no complete word is held
module if_fetch (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  if_fetch_if.master  mem,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stall_if
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BUF_W  = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BYTE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [WORD_W-1:0] if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  // Only the fetch-hold bit of the stall vector matters here.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  // Next-state and registered-output logic; branch overrides every other event.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    if (branch_flag) begin
      state_d    = ST_BYTE;
      idx_d      = '0;
      pc_d       = branch_target;
      if_valid_d = 1'b0;
      mem_req_d  = 1'b1;
      mem_addr_d = branch_target;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_BYTE;
          idx_d      = '0;
          if_valid_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
        ST_BYTE: begin
          if (mem.mem_ready) begin
            if (idx_q == IDX_W'(3)) begin
              state_d    = ST_HOLD;
              if_inst_d  = {mem.mem_rdata, buf_q};
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              mem_req_d  = 1'b0;
            end else begin
              case (idx_q)
                IDX_W'(0): buf_d[7:0]   = mem.mem_rdata;
                IDX_W'(1): buf_d[15:8]  = mem.mem_rdata;
                default:   buf_d[23:16] = mem.mem_rdata;
              endcase
              idx_d      = idx_q + IDX_W'(1);
              mem_addr_d = pc_q + ADDR_W'(idx_d);
            end
          end
        end
        ST_HOLD: begin
          if (!stall[0]) begin
            state_d    = ST_BYTE;
            idx_d      = '0;
            pc_d       = pc_q + ADDR_W'(4);
            if_valid_d = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q + ADDR_W'(4);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          if_valid_d = 1'b0;
          mem_req_d  = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pc_q       <= '0;
      buf_q      <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;
  assign if_valid     = if_valid_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign stall_if     = (state_q != ST_HOLD);
endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by randomized traffic,
// checked by a scoreboard of expected (pc, word) deliveries.
module tb_if_fetch;
  logic        clk;
  logic        rst_in;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stall_if;

  if_fetch_if mem_bus ();

  if_fetch dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .mem           (mem_bus.master),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_valid      (if_valid),
    .stall_if      (stall_if)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wait_cnt = 0;
  bit          mon_en   = 1'b0;
  logic        prev_valid = 1'b0;
  logic [31:0] cur_pc   = '0;
  logic [31:0] hold_pc  = '0;
  logic [31:0] hold_inst = '0;
  logic [4:0]  stall_hi = '0;

  // Memory contents: bytes 0..3 hold the word 0x00000013, elsewhere a hash.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] lo;
    if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
    lo = a[7:0];
    return 8'(lo * 8'd37) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
            mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  assign mem_bus.mem_rdata = mem_byte(mem_bus.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = word_at(pc);
    exp_q.push_back(e);
    wait_cnt = 0;
  endtask

  // Drive one cycle of inputs and update the reference model for the coming edge:
  // reset restarts at 0, a branch restarts at its target, an accepted word
  // (held word with stall[0] low) is followed by the word 4 bytes on.
  task automatic cyc(input logic r, input logic b, input logic [31:0] t,
                     input logic s0, input logic rdy);
    @(negedge clk);
    #1;
    rst_in        = r;
    branch_flag   = b;
    branch_target = t;
    stall         = {stall_hi, s0};
    mem_bus.mem_ready = rdy;
    if (r) begin
      exp_q.delete();
      push_exp(32'd0);
    end else if (b) begin
      exp_q.delete();
      push_exp(t);
    end else if (if_valid === 1'b1 && !s0) begin
      push_exp(cur_pc + 32'd4);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},    32'(if_valid), 32'd0);
    chk({tag, "_mem_req"},  32'(mem_bus.mem_req), 32'd0);
    chk({tag, "_mem_addr"}, mem_bus.mem_addr, 32'd0);
    chk({tag, "_if_pc"},    if_pc, 32'd0);
    chk({tag, "_if_inst"},  if_inst, 32'd0);
    chk({tag, "_stall_if"}, 32'(stall_if), 32'd1);
  endtask

  // Monitor: pops an expectation whenever a new word is presented.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("stall_if_vs_valid", 32'(stall_if), 32'(!if_valid));
      if (if_valid === 1'b1) chk("mem_req_in_hold", 32'(mem_bus.mem_req), 32'd0);
      if (if_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word_pc", if_pc, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_pc", if_pc, e.pc);
          chk("word_inst", if_inst, e.inst);
          cur_pc = e.pc;
        end
        hold_pc   = if_pc;
        hold_inst = if_inst;
        wait_cnt  = 0;
      end else if (if_valid === 1'b1) begin
        chk("hold_pc_stable", if_pc, hold_pc);
        chk("hold_inst_stable", if_inst, hold_inst);
      end else if (exp_q.size() != 0) begin
        wait_cnt++;
        if (wait_cnt > 400) begin
          chk("delivery_timeout", 32'(wait_cnt), 32'd0);
          exp_q.delete();
          wait_cnt = 0;
        end
      end
    end
    prev_valid = if_valid;
  end

  initial begin
    int k;
    rst_in = 1'b1;
    branch_flag = 1'b0;
    branch_target = '0;
    stall = '0;
    mem_bus.mem_ready = 1'b0;

    // Reset release, first word from address 0 with ready every cycle.
    cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk_reset_vals("reset");
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      chk("first_mem_addr", mem_bus.mem_addr, 32'(i));
      chk("first_mem_req", 32'(mem_bus.mem_req), 32'd1);
      chk("first_stall_if", 32'(stall_if), 32'd1);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_inst", if_inst, 32'h0000_0013);
    chk("first_pc", if_pc, 32'd0);
    chk("first_stall_if_hold", 32'(stall_if), 32'd0);

    // Held under stall for 3 cycles, then released.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      chk("stall_hold_valid", 32'(if_valid), 32'd1);
      chk("stall_hold_inst", if_inst, 32'h0000_0013);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("release_mem_addr", mem_bus.mem_addr, 32'd4);
    chk("release_stall_if", 32'(stall_if), 32'd1);
    chk("release_valid", 32'(if_valid), 32'd0);

    // Ready every third cycle: address holds between bytes.
    k = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1, (i % 3) == 2);
      chk("gap_mem_addr", mem_bus.mem_addr, 32'd4 + 32'(k));
      chk("gap_stall_if", 32'(stall_if), 32'd1);
      if ((i % 3) == 2) k++;
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("gap_word_pc", if_pc, 32'd4);

    // Branch coincident with the idx=2 byte: byte dropped, refetch from 0x100.
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("pre_branch_addr0", mem_bus.mem_addr, 32'd8);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("pre_branch_addr1", mem_bus.mem_addr, 32'd9);
    cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    chk("pre_branch_addr2", mem_bus.mem_addr, 32'd10);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      chk("branch_mem_addr", mem_bus.mem_addr, 32'h100 + 32'(i));
      chk("branch_no_valid", 32'(if_valid), 32'd0);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("branch_word_pc", if_pc, 32'h100);

    // Fetch at 0xFFFFFFFC, release: next fetch wraps to address 0.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      chk("wrap_fetch_addr", mem_bus.mem_addr, 32'hFFFF_FFFC + 32'(i));
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("wrap_word_pc", if_pc, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("wrap_mem_addr", mem_bus.mem_addr, 32'd0);

    // Reset at idx=2 with coincident branch and ready: back to reset state.
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("mid_rst_addr1", mem_bus.mem_addr, 32'd1);
    cyc(1'b1, 1'b1, 32'h55, 1'b1, 1'b1);
    chk("mid_rst_addr2", mem_bus.mem_addr, 32'd2);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk_reset_vals("mid_rst");
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("refetch_addr", mem_bus.mem_addr, 32'd0);
    chk("refetch_req", 32'(mem_bus.mem_req), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic        r, b, s0, rdy;
      logic [31:0] t;
      r   = ($urandom_range(0, 299) == 0);
      b   = ($urandom_range(0, 39) == 0);
      s0  = ($urandom_range(0, 1) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      t   = $urandom();
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      stall_hi = 5'($urandom());
      cyc(r, b, t, s0, rdy);
    end
    stall_hi = '0;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
